// File: rtl/aes_pkg.sv
// Shared AES types and tables used by the round-key queue: the Rcon
// constants, the forward S-box and the key/word types.
package aes_pkg;
    typedef logic [127:0] key_t;
    typedef logic [31:0]  word_t;

    localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Row r of the literal holds S-box entries 16*r .. 16*r+15, left to right.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    assign y_o = sbox(a_i);
endmodule

// File: rtl/round_key_queue.sv
// FWFT queue of 128-bit key blocks with an AES key-expansion g-function on
// the head's last word and a round-constant index that advances per pop.
module round_key_queue
    import aes_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ROUND_LIMIT = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  key_t                   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output key_t                   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output word_t                  g_word,
    output logic [7:0]             rcon_out,
    input  logic                   rcon_restart,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    key_t            mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic            push, pop;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        ovf_d  = ovf_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (in_valid && full) ovf_d = 1'b1;
        if (rcon_restart)
            idx_d = '0;
        else if (pop)
            idx_d = (idx_q == 4'(ROUND_LIMIT - 1)) ? 4'd0 : idx_q + 4'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is never cleared; reset only suppresses a same-cycle write.
    always_ff @(posedge clock) begin
        if (!reset && push) mem_q[wptr_q] <= in_data;
    end

    assign out_data = mem_q[rptr_q];
    assign rcon_out = RCON[idx_q];

    word_t rot, sub;
    assign rot = {out_data[23:0], out_data[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .a_i(rot[8*i +: 8]),
            .y_o(sub[8*i +: 8])
        );
    end

    assign g_word = {sub[31:24] ^ rcon_out, sub[23:0]};
endmodule

// File: tb/tb_round_key_queue.sv
// Randomised and directed check of round_key_queue against a queue-based
// model with an arithmetically derived S-box and Rcon sequence.
module tb_round_key_queue;
    localparam int DEPTH = 16;
    localparam int RL    = 10;

    logic         clock = 1'b0;
    logic         reset, in_valid, out_ready, rcon_restart;
    logic [127:0] in_data;
    logic         in_ready, out_valid, empty, full, overflow;
    logic [127:0] out_data;
    logic [31:0]  g_word;
    logic [7:0]   rcon_out;
    logic [4:0]   count;

    round_key_queue #(.DEPTH(DEPTH), .ROUND_LIMIT(RL)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .g_word(g_word), .rcon_out(rcon_out),
        .rcon_restart(rcon_restart), .empty(empty), .full(full),
        .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    logic [127:0] mq[$];
    int           m_idx;
    bit           m_ovf;
    logic [7:0]   sb [256];
    logic [7:0]   rc [10];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 0;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            sb[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        rc[0] = 8'h01;
        for (int i = 1; i < 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
    endtask

    function automatic logic [31:0] exp_g(input logic [127:0] k, input logic [7:0] r);
        logic [7:0] b12 = k[31:24], b13 = k[23:16], b14 = k[15:8], b15 = k[7:0];
        return {sb[b13] ^ r, sb[b14], sb[b15], sb[b12]};
    endfunction

    task automatic check_all();
        chk("count", 128'(count), 128'(mq.size()));
        chk("empty", 128'(empty), 128'(mq.size() == 0));
        chk("full", 128'(full), 128'(mq.size() == DEPTH));
        chk("in_ready", 128'(in_ready), 128'(mq.size() != DEPTH));
        chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
        chk("rcon_out", 128'(rcon_out), 128'(rc[m_idx]));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0]);
            chk("g_word", 128'(g_word), 128'(exp_g(mq[0], rc[m_idx])));
        end
    endtask

    // Drive one cycle's inputs from the falling edge, update the model at the
    // rising edge, then check at the next falling edge.
    task automatic cyc(input bit v, input logic [127:0] d, input bit r,
                       input bit rs, input bit rst);
        bit pop_ok, push_ok;
        in_valid = v; in_data = d; out_ready = r; rcon_restart = rs; reset = rst;
        @(posedge clock);
        if (rst) begin
            mq.delete(); m_idx = 0; m_ovf = 0;
        end else begin
            pop_ok  = r && mq.size() > 0;
            push_ok = v && mq.size() < DEPTH;
            if (v && mq.size() == DEPTH) m_ovf = 1;
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
            if (rs) m_idx = 0;
            else if (pop_ok) m_idx = (m_idx + 1) % RL;
        end
        @(negedge clock);
        in_valid = 0; out_ready = 0; rcon_restart = 0; reset = 0;
        check_all();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] fill [DEPTH];

    initial begin
        build_tables();
        reset = 1; in_valid = 0; out_ready = 0; rcon_restart = 0; in_data = '0;
        mq.delete(); m_idx = 0; m_ovf = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_rcon", 128'(rcon_out), 128'h01);
        check_all();

        // Single push of the reference key.
        cyc(1, K0, 0, 0, 0);
        chk("k0_g", 128'(g_word), 128'hD6AB76FE);
        chk("k0_count", 128'(count), 128'd1);
        // Pop with a same-key push; index advances to Rcon 02.
        cyc(1, K0, 1, 0, 0);
        chk("k0b_rcon", 128'(rcon_out), 128'h02);

        // Fill, overflow, drain in FIFO order.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            fill[i] = rnd128();
            cyc(1, fill[i], 0, 0, 0);
        end
        chk("fill_full", 128'(full), 128'd1);
        chk("fill_rdy", 128'(in_ready), 128'd0);
        cyc(1, rnd128(), 1, 0, 0);  // push while full is dropped even with a pop
        chk("ovf_set", 128'(overflow), 128'd1);
        chk("ovf_cnt", 128'(count), 128'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) begin
            chk("fifo_order", out_data, fill[i]);
            cyc(0, 0, 1, 0, 0);
        end
        cyc(0, 0, 1, 0, 0);  // pop on empty is ignored
        chk("no_underflow", 128'(count), 128'd0);

        // Rcon sequence over 11 pops, restart does not touch contents.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(1, rnd128(), 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            chk("rcon_seq", 128'(rcon_out), 128'(rc[i % 10]));
            cyc(0, 0, 1, 0, 0);
        end
        chk("rcon_wrap", 128'(rcon_out), 128'h02);
        cyc(0, 0, 1, 1, 0);
        chk("restart", 128'(rcon_out), 128'h01);

        // Simultaneous push/pop at count=3 and at empty.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, rnd128(), 0, 0, 0);
        cyc(1, rnd128(), 1, 0, 0);
        chk("pp_cnt3", 128'(count), 128'd3);
        cyc(0, 0, 0, 0, 1);
        cyc(1, rnd128(), 1, 0, 0);
        chk("pp_empty", 128'(count), 128'd1);

        // Mid-stream reset at count=5, idx=4, with other controls active.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, rnd128(), 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("pre_rst_cnt", 128'(count), 128'd5);
        cyc(1, rnd128(), 1, 1, 1);
        chk("mid_rst_cnt", 128'(count), 128'd0);
        chk("mid_rst_rcon", 128'(rcon_out), 128'h01);

        // Random traffic with shifting push/pop bias.
        for (int i = 0; i < 1500; i++) begin
            int pv = ((i / 150) % 2 == 0) ? 75 : 35;
            cyc($urandom_range(99) < pv, rnd128(), $urandom_range(99) < (100 - pv),
                $urandom_range(99) < 4, $urandom_range(199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
